npm_toggle_timer_arbiter: RTL and testbench

Round-robin arbiter that shares one NPM_Toggle_TIMER instance among several per-way command engines in the NAND channel controller. It accepts timed-hold requests (option, target way, duration), serialises them onto the timer's start interface, and returns accept/done pulses to the winning requester. The one-hot grant vector steers the channel's PO-signal mux toward the timer while a hold is in progress.

---
 rtl/npm_toggle_pkg.sv | 18 +
 rtl/npm_toggle_timer_arbiter_if.sv | 40 ++++
 rtl/npm_toggle_rr_pick.sv | 27 ++
 rtl/npm_toggle_timer_arbiter.sv | 100 ++++++++++
 tb/tb_npm_toggle_timer_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/npm_toggle_pkg.sv
// Shared definitions for the NPM toggle timer arbiter: FSM encodings,
// option bit positions and the data-count width.
package npm_toggle_pkg;

   typedef enum logic [3:0] {
      ARB_RESET = 4'b0001,
      ARB_IDLE  = 4'b0010,
      ARB_ISSUE = 4'b0100,
      ARB_RUN   = 4'b1000
   } arb_state_e;

   localparam int OPT_CE  = 0;
   localparam int OPT_DQS = 1;
   localparam int OPT_SIG = 2;
   localparam int OPT_W   = OPT_SIG + 1;
   localparam int DATA_W  = 16;

endpackage

// File: rtl/npm_toggle_timer_arbiter_if.sv
// Requester and timer-side bundle of the timer arbiter; the arbiter takes the
// slave view, requesters/timer (or a bench) take the master view.
interface npm_toggle_timer_arbiter_if #(
   parameter int NumberOfRequesters = 4,
   parameter int NumberOfWays       = 4
);
   import npm_toggle_pkg::*;

   localparam int N = NumberOfRequesters;
   localparam int W = NumberOfWays;

   logic [N-1:0]        iReqStart;
   logic [OPT_W*N-1:0]  iReqOption;
   logic [W*N-1:0]      iReqTargetWay;
   logic [DATA_W*N-1:0] iReqNumOfData;
   logic [N-1:0]        oReqAccept;
   logic [N-1:0]        oReqDone;
   logic [N-1:0]        oGrant;
   logic                iTimerReady;
   logic                iTimerLastStep;
   logic                oTimerStart;
   logic [OPT_W-1:0]    oTimerOption;
   logic [W-1:0]        oTimerTargetWay;
   logic [DATA_W-1:0]   oTimerNumOfData;

   modport master (
      output iReqStart, iReqOption, iReqTargetWay, iReqNumOfData,
      output iTimerReady, iTimerLastStep,
      input  oReqAccept, oReqDone, oGrant,
      input  oTimerStart, oTimerOption, oTimerTargetWay, oTimerNumOfData
   );

   modport slave (
      input  iReqStart, iReqOption, iReqTargetWay, iReqNumOfData,
      input  iTimerReady, iTimerLastStep,
      output oReqAccept, oReqDone, oGrant,
      output oTimerStart, oTimerOption, oTimerTargetWay, oTimerNumOfData
   );

endinterface

// File: rtl/npm_toggle_rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1,
// wrapping modulo N.
module npm_toggle_rr_pick #(
   parameter int N  = 4,
   parameter int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] last_i,
   output logic [N-1:0]  win_o,
   output logic          vld_o
);

   always_comb begin : pick
      logic [LW-1:0] idx;
      idx   = '0;
      win_o = '0;
      vld_o = 1'b0;
      for (int off = 1; off <= N; off++) begin
         idx = LW'((int'(last_i) + off) % N);
         if (!vld_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            vld_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/npm_toggle_timer_arbiter.sv
// Shares one NPM_Toggle_TIMER among N command engines: picks a requester
// round-robin, issues one start pulse and returns accept/done pulses.
module npm_toggle_timer_arbiter
   import npm_toggle_pkg::*;
#(
   parameter int NumberOfRequesters = 4,
   parameter int NumberOfWays       = 4
) (
   input logic                      iSystemClock,
   input logic                      iReset,
   npm_toggle_timer_arbiter_if.slave bus
);

   localparam int N  = NumberOfRequesters;
   localparam int W  = NumberOfWays;
   localparam int LW = (N > 1) ? $clog2(N) : 1;

   arb_state_e        state_q;
   logic [LW-1:0]     last_q;
   logic [N-1:0]      grant_q;
   logic [OPT_W-1:0]  opt_q;
   logic [W-1:0]      way_q;
   logic [DATA_W-1:0] num_q;

   logic [N-1:0]      pick_win;
   logic              pick_vld;
   logic [LW-1:0]     win_idx;
   logic [OPT_W-1:0]  opt_d;
   logic [W-1:0]      way_d;
   logic [DATA_W-1:0] num_d;

   npm_toggle_rr_pick #(.N(N), .LW(LW)) u_pick (
      .req_i  (bus.iReqStart),
      .last_i (last_q),
      .win_o  (pick_win),
      .vld_o  (pick_vld)
   );

   // Mux the winner's fields out of the flattened request buses.
   always_comb begin
      win_idx = '0;
      opt_d   = '0;
      way_d   = '0;
      num_d   = '0;
      for (int i = 0; i < N; i++) begin
         if (pick_win[i]) begin
            win_idx = LW'(i);
            opt_d   = bus.iReqOption[OPT_W*i +: OPT_W];
            way_d   = bus.iReqTargetWay[W*i +: W];
            num_d   = bus.iReqNumOfData[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         state_q <= ARB_RESET;
         last_q  <= LW'(N - 1);
         grant_q <= '0;
         opt_q   <= '0;
         way_q   <= '0;
         num_q   <= '0;
      end else begin
         case (state_q)
            ARB_RESET: state_q <= ARB_IDLE;
            ARB_IDLE: begin
               if (bus.iTimerReady && pick_vld) begin
                  grant_q <= pick_win;
                  last_q  <= win_idx;
                  opt_q   <= opt_d;
                  way_q   <= way_d;
                  num_q   <= num_d;
                  state_q <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: state_q <= ARB_RUN;
            ARB_RUN: begin
               if (bus.iTimerLastStep) begin
                  grant_q <= '0;
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   // Pulses come only from registered state/grant, so reset silences them at once.
   assign bus.oTimerStart     = (state_q == ARB_ISSUE);
   assign bus.oReqAccept      = (state_q == ARB_ISSUE) ? grant_q : '0;
   assign bus.oReqDone        = (state_q == ARB_RUN && bus.iTimerLastStep) ? grant_q : '0;
   assign bus.oGrant          = grant_q;
   assign bus.oTimerOption    = opt_q;
   assign bus.oTimerTargetWay = way_q;
   assign bus.oTimerNumOfData = num_q;

endmodule

// File: tb/tb_npm_toggle_timer_arbiter.sv
// Directed bench for the timer arbiter; the timer is played by hand from the
// stimulus sequence.
module tb_npm_toggle_timer_arbiter;
   import npm_toggle_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   npm_toggle_timer_arbiter_if #(.NumberOfRequesters(4), .NumberOfWays(4)) b ();

   npm_toggle_timer_arbiter #(.NumberOfRequesters(4), .NumberOfWays(4)) dut (
      .iSystemClock (clk),
      .iReset       (rst),
      .bus          (b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Step onto the IDLE edge and check the ISSUE cycle, then drop the request.
   task automatic issue_chk(input logic [3:0] who, input logic [2:0] opt,
                            input logic [3:0] way, input logic [15:0] num);
      step();
      #1;
      chk("accept", b.oReqAccept, who);
      chk("start", b.oTimerStart, 1);
      chk("grant", b.oGrant, who);
      chk("fields", {b.oTimerOption, b.oTimerTargetWay, b.oTimerNumOfData}, {opt, way, num});
      b.iReqStart = b.iReqStart & ~who;
   endtask

   // Timer model: LastStep in the cycle K+1 cycles after the start edge.
   task automatic hold(input int k, input logic [3:0] who);
      step();
      b.iTimerReady = 1'b0;
      #1;
      chk("run_nopulse", {b.oTimerStart, b.oReqAccept}, 0);
      chk("run_grant", b.oGrant, who);
      for (int i = 0; i < k; i++) begin
         step();
         #1;
         chk("run_nodone", b.oReqDone, 0);
      end
      step();
      b.iTimerLastStep = 1'b1;
      #1;
      chk("done", b.oReqDone, who);
      chk("done_grant", b.oGrant, who);
      step();
      b.iTimerLastStep = 1'b0;
      b.iTimerReady    = 1'b1;
      #1;
      chk("idle_grant", b.oGrant, 0);
      chk("idle_done", b.oReqDone, 0);
   endtask

   task automatic grant_cycle(input logic [3:0] who, input logic [2:0] opt,
                              input logic [3:0] way, input logic [15:0] num);
      issue_chk(who, opt, way, num);
      hold(int'(num), who);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      logic [3:0] who;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      b.iReqStart      = '0;
      b.iReqOption     = '0;
      b.iReqTargetWay  = '0;
      b.iReqNumOfData  = '0;
      b.iTimerReady    = 1'b1;
      b.iTimerLastStep = 1'b0;

      step();
      #1;
      chk("rst_outs", {b.oReqAccept, b.oReqDone, b.oGrant, b.oTimerStart}, 0);
      chk("rst_fields", {b.oTimerOption, b.oTimerTargetWay, b.oTimerNumOfData}, 0);
      rst = 1'b0;
      step();

      // Single request from requester 2, count 3.
      b.iReqOption    = 12'b000_101_000_000;
      b.iReqTargetWay = 16'h0400;
      b.iReqNumOfData = {16'd0, 16'd3, 16'd0, 16'd0};
      b.iReqStart     = 4'b0100;
      issue_chk(4'b0100, 3'b101, 4'b0100, 16'd3);
      chk("opt_sig", b.oTimerOption[OPT_SIG], 1);
      chk("opt_dqs", b.oTimerOption[OPT_DQS], 0);
      chk("opt_ce", b.oTimerOption[OPT_CE], 1);
      b.iReqOption    = '1;
      b.iReqTargetWay = '1;
      hold(3, 4'b0100);
      chk("fields_kept", {b.oTimerOption, b.oTimerTargetWay}, {3'b101, 4'b0100});

      // All four at once after reset: order 0,1,2,3.
      do_reset();
      b.iReqOption    = {3'd4, 3'd3, 3'd2, 3'd1};
      b.iReqTargetWay = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
      b.iReqNumOfData = '0;
      b.iReqStart     = 4'b1111;
      grant_cycle(4'b0001, 3'd1, 4'b0001, 16'd0);
      grant_cycle(4'b0010, 3'd2, 4'b0010, 16'd0);
      grant_cycle(4'b0100, 3'd3, 4'b0100, 16'd0);
      grant_cycle(4'b1000, 3'd4, 4'b1000, 16'd0);

      // Fairness: 0 and 3 keep re-requesting.
      b.iReqStart = 4'b1001;
      for (int g = 0; g < 8; g++) begin
         who = (g % 2 == 0) ? 4'b0001 : 4'b1000;
         if (g % 2 == 0) grant_cycle(who, 3'd1, 4'b0001, 16'd0);
         else            grant_cycle(who, 3'd4, 4'b1000, 16'd0);
         b.iReqStart = b.iReqStart | who;
      end
      b.iReqStart = '0;

      // Timer busy: request from 1 waits for iTimerReady.
      b.iTimerReady = 1'b0;
      b.iReqStart   = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("busy_wait", {b.oTimerStart, b.oReqAccept, b.oGrant}, 0);
      end
      b.iTimerReady = 1'b1;
      grant_cycle(4'b0010, 3'd2, 4'b0010, 16'd0);

      // Reset in the middle of a 100-step hold.
      b.iReqNumOfData[48 +: 16] = 16'd100;
      b.iReqStart = 4'b1000;
      issue_chk(4'b1000, 3'd4, 4'b1000, 16'd100);
      step();
      b.iTimerReady = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         #1;
         chk("long_nodone", b.oReqDone, 0);
      end
      rst = 1'b1;
      #1;
      chk("midrun_outs", {b.oReqAccept, b.oReqDone, b.oGrant, b.oTimerStart}, 0);
      chk("midrun_fields", {b.oTimerOption, b.oTimerTargetWay, b.oTimerNumOfData}, 0);
      b.iTimerReady = 1'b1;
      step();
      rst = 1'b0;
      step();
      #1;
      chk("post_rst_grant", b.oGrant, 0);
      b.iReqNumOfData[48 +: 16] = 16'd2;
      b.iReqStart = 4'b1001;
      grant_cycle(4'b0001, 3'd1, 4'b0001, 16'd0);
      grant_cycle(4'b1000, 3'd4, 4'b1000, 16'd2);

      // Withdrawal: requester 1 pulses while busy and drops before IDLE.
      b.iReqNumOfData[0 +: 16] = 16'd1;
      b.iReqStart = 4'b0001;
      issue_chk(4'b0001, 3'd1, 4'b0001, 16'd1);
      b.iReqStart = 4'b0010;
      step();
      b.iTimerReady = 1'b0;
      #1;
      chk("wd_grant", b.oGrant, 4'b0001);
      step();
      b.iReqStart = 4'b0100;
      #1;
      chk("wd_nodone", b.oReqDone, 0);
      step();
      b.iTimerLastStep = 1'b1;
      #1;
      chk("wd_done", b.oReqDone, 4'b0001);
      step();
      b.iTimerLastStep = 1'b0;
      b.iTimerReady    = 1'b1;
      #1;
      chk("wd_idle", b.oGrant, 0);
      grant_cycle(4'b0100, 3'd3, 4'b0100, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk("wd_quiet", {b.oReqAccept, b.oTimerStart, b.oGrant}, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
